// File: rtl/fpall_pkg.sv
// ---------------------------------------------------------------------------
// fpall_pkg
// Shared bf16 definitions for the floating-point multiplier slice.
//   bf16_t        : packed {sign, exp[7:0], frac[6:0]}
//   bf16_flags_t  : packed {nv, of, uf, nx} exception flags (MSB = nv)
//   BF16_BIAS     : exponent bias (127)
//   BF16_QNAN     : canonical quiet NaN returned for every invalid result
// ---------------------------------------------------------------------------
package fpall_pkg;

    localparam int          BF16_BIAS = 127;
    localparam logic [15:0] BF16_QNAN = 16'h7FC0;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] frac;
    } bf16_t;

    typedef struct packed {
        logic nv;
        logic of;
        logic uf;
        logic nx;
    } bf16_flags_t;

endpackage

// File: rtl/fpmul_bf16_lane.sv
// ---------------------------------------------------------------------------
// fpmul_bf16_lane
// Combinational single-lane bf16 multiplier. Subnormal inputs are read as
// signed zero, results are rounded to nearest-even before the range checks,
// overflow saturates to signed Inf and underflow flushes to signed zero.
// Optional feature macro: FPMUL_BF16_FLAGS_EN adds the o_flags output.
// Ports:
//   i_x, i_y : bf16 operands
//   o_r      : bf16 product
//   o_flags  : {nv, of, uf, nx} for this lane (only with FPMUL_BF16_FLAGS_EN)
// ---------------------------------------------------------------------------
module fpmul_bf16_lane
    import fpall_pkg::*;
(
    input  bf16_t       i_x,
    input  bf16_t       i_y,
`ifdef FPMUL_BF16_FLAGS_EN
    output bf16_flags_t o_flags,
`endif
    output bf16_t       o_r
);

    logic               w_x_zero, w_x_inf, w_x_nan;
    logic               w_y_zero, w_y_inf, w_y_nan;
    logic               w_sign;
    logic               w_invalid;
    logic [15:0]        w_prod;
    logic               w_norm;
    logic [6:0]         w_frac_trunc;
    logic               w_guard;
    logic               w_sticky;
    logic               w_round_up;
    logic [7:0]         w_frac_rnd;
    logic signed [10:0] w_exp;
    logic               w_ovf;
    logic               w_unf;

    // exp==0 covers both true zero and subnormals (flushed on input)
    assign w_x_zero = (i_x.exp == 8'h00);
    assign w_x_inf  = (i_x.exp == 8'hFF) && (i_x.frac == 7'h00);
    assign w_x_nan  = (i_x.exp == 8'hFF) && (i_x.frac != 7'h00);
    assign w_y_zero = (i_y.exp == 8'h00);
    assign w_y_inf  = (i_y.exp == 8'hFF) && (i_y.frac == 7'h00);
    assign w_y_nan  = (i_y.exp == 8'hFF) && (i_y.frac != 7'h00);

    assign w_sign    = i_x.sign ^ i_y.sign;
    assign w_invalid = w_x_nan || w_y_nan || (w_x_inf && w_y_zero) || (w_x_zero && w_y_inf);

    // 1.f x 1.f lies in [1,4): bit 15 set means the product needs one right shift
    assign w_prod       = 16'({1'b1, i_x.frac}) * 16'({1'b1, i_y.frac});
    assign w_norm       = w_prod[15];
    assign w_frac_trunc = w_norm ? w_prod[14:8] : w_prod[13:7];
    assign w_guard      = w_norm ? w_prod[7]    : w_prod[6];
    assign w_sticky     = w_norm ? (|w_prod[6:0]) : (|w_prod[5:0]);
    assign w_round_up   = w_guard & (w_sticky | w_frac_trunc[0]);

    // Carry out of the rounded fraction means 1.1111111 rounded up to 10.0000000;
    // the fraction field is then already zero, only the exponent bumps.
    assign w_frac_rnd = {1'b0, w_frac_trunc} + {7'h00, w_round_up};
    assign w_exp = $signed({3'b000, i_x.exp} + {3'b000, i_y.exp}
                         + {10'h000, w_norm} + {10'h000, w_frac_rnd[7]}
                         - 11'(BF16_BIAS));

    assign w_ovf = (w_exp >= 11'sd255);
    assign w_unf = (w_exp <= 11'sd0);

    always_comb begin
        o_r = {w_sign, w_exp[7:0], w_frac_rnd[6:0]};
        if (w_invalid) begin
            o_r = BF16_QNAN;
        end else if (w_x_inf || w_y_inf) begin
            o_r = {w_sign, 8'hFF, 7'h00};
        end else if (w_x_zero || w_y_zero) begin
            o_r = {w_sign, 8'h00, 7'h00};
        end else if (w_ovf) begin
            o_r = {w_sign, 8'hFF, 7'h00};
        end else if (w_unf) begin
            o_r = {w_sign, 8'h00, 7'h00};
        end
    end

`ifdef FPMUL_BF16_FLAGS_EN
    logic w_snan;
    logic w_finite;

    // Only signalling NaNs (quiet bit clear) and Inf x 0 raise invalid
    assign w_snan   = (w_x_nan && !i_x.frac[6]) || (w_y_nan && !i_y.frac[6]);
    assign w_finite = !w_invalid && !w_x_inf && !w_y_inf && !w_x_zero && !w_y_zero;

    always_comb begin
        o_flags    = '0;
        o_flags.nv = (w_x_inf && w_y_zero) || (w_x_zero && w_y_inf) || w_snan;
        if (w_finite) begin
            o_flags.of = w_ovf;
            o_flags.uf = w_unf && !w_ovf;
            o_flags.nx = w_ovf || w_guard || w_sticky;
        end
    end
`endif

endmodule

// File: rtl/fpmul_bf16_simd.sv
// ---------------------------------------------------------------------------
// fpmul_bf16_simd
// LANES-wide bf16 SIMD multiplier with a valid/ready handshake and a
// PIPE_STAGES-deep register pipeline that advances globally
// (adv = !out_valid || out_ready). Lane arithmetic sits in front of stage 0.
// Optional feature macro: FPMUL_BF16_FLAGS_EN adds per-lane exception flags
// aligned with out_r, sticky flags and a flag clear input.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input beat handshake
//   in_x, in_y            : packed operands, lane i at [16i+15:16i]
//   in_tag                : sideband echoed with the result
//   out_valid/out_ready   : output beat handshake
//   out_r, out_tag        : packed products and their tag
//   out_flags             : {nv,of,uf,nx} per lane (FPMUL_BF16_FLAGS_EN)
//   sticky_flags          : accumulated out_flags   (FPMUL_BF16_FLAGS_EN)
//   flags_clr             : clears sticky_flags     (FPMUL_BF16_FLAGS_EN)
// ---------------------------------------------------------------------------
module fpmul_bf16_simd
    import fpall_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*LANES-1:0]   in_x,
    input  logic [16*LANES-1:0]   in_y,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*LANES-1:0]   out_r,
`ifdef FPMUL_BF16_FLAGS_EN
    output logic [4*LANES-1:0]    out_flags,
    output logic [4*LANES-1:0]    sticky_flags,
    input  logic                  flags_clr,
`endif
    output logic [TAG_W-1:0]      out_tag
);

    logic                                   w_adv;
    logic [16*LANES-1:0]                    w_lane_r;
    logic [PIPE_STAGES-1:0]                 r_valid;
    logic [PIPE_STAGES-1:0][16*LANES-1:0]   r_data;
    logic [PIPE_STAGES-1:0][TAG_W-1:0]      r_tag;

`ifdef FPMUL_BF16_FLAGS_EN
    logic [4*LANES-1:0]                     w_lane_flags;
    logic [PIPE_STAGES-1:0][4*LANES-1:0]    r_flags;
    logic [4*LANES-1:0]                     r_sticky;
`endif

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            fpmul_bf16_lane u_lane (
                .i_x     (in_x[16*gi +: 16]),
                .i_y     (in_y[16*gi +: 16]),
`ifdef FPMUL_BF16_FLAGS_EN
                .o_flags (w_lane_flags[4*gi +: 4]),
`endif
                .o_r     (w_lane_r[16*gi +: 16])
            );
        end
    endgenerate

    // Stage 0 captures the lane results; every later stage copies its
    // predecessor. A bubble simply shifts through as valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_data  <= '0;
            r_tag   <= '0;
        end else if (w_adv) begin
            r_valid[0] <= in_valid;
            r_data[0]  <= w_lane_r;
            r_tag[0]   <= in_tag;
            for (int k = 1; k < PIPE_STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_data[k]  <= r_data[k-1];
                r_tag[k]   <= r_tag[k-1];
            end
        end
    end

    assign out_valid = r_valid[PIPE_STAGES-1];
    assign out_r     = r_data[PIPE_STAGES-1];
    assign out_tag   = r_tag[PIPE_STAGES-1];

`ifdef FPMUL_BF16_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (w_adv) begin
            r_flags[0] <= w_lane_flags;
            for (int k = 1; k < PIPE_STAGES; k++) begin
                r_flags[k] <= r_flags[k-1];
            end
        end
    end

    // Clear is applied first so flags of a beat leaving this cycle survive it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (flags_clr ? '0 : r_sticky)
                      | ((out_valid && out_ready) ? out_flags : '0);
        end
    end

    assign out_flags    = r_flags[PIPE_STAGES-1];
    assign sticky_flags = r_sticky;
`endif

endmodule

// File: tb/tb_fpmul_bf16_simd.sv
// ---------------------------------------------------------------------------
// tb_fpmul_bf16_simd
// Directed and randomized bench for fpmul_bf16_simd (LANES=2, PIPE_STAGES=2).
// Expected products come from an integer reference model that forms the exact
// significand product and rounds it to 8 significant bits; a scoreboard
// queue tracks accepted beats and every output transfer is compared.
// ---------------------------------------------------------------------------
module tb_fpmul_bf16_simd;

    localparam int LANES = 2;
    localparam int PIPE  = 2;
    localparam int TAG_W = 4;
    localparam int DW    = 16 * LANES;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    in_x = '0;
    logic [DW-1:0]    in_y = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [DW-1:0]    out_r;
    logic [TAG_W-1:0] out_tag;
`ifdef FPMUL_BF16_FLAGS_EN
    logic [4*LANES-1:0] out_flags;
    logic [4*LANES-1:0] sticky_flags;
    logic               flags_clr = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [TAG_W-1:0]   tag;
        logic [DW-1:0]      r;
        logic [4*LANES-1:0] fl;
    } exp_t;

    exp_t             sb[$];
    logic [TAG_W-1:0] seen_tags[$];

    always #5 clk = ~clk;

    fpmul_bf16_simd #(
        .LANES       (LANES),
        .PIPE_STAGES (PIPE),
        .TAG_W       (TAG_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_r        (out_r),
`ifdef FPMUL_BF16_FLAGS_EN
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .flags_clr    (flags_clr),
`endif
        .out_tag      (out_tag)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    // Returns {flags[3:0] = {nv,of,uf,nx}, result[15:0]}
    function automatic logic [19:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        int     ex, ey, fx, fy, e, msb, sh;
        longint p, q, rem, half;
        logic   s;
        bit     xz, xi, xn, yz, yi, yn, inv;
        ex = int'(x[14:7]);  fx = int'(x[6:0]);
        ey = int'(y[14:7]);  fy = int'(y[6:0]);
        s  = x[15] ^ y[15];
        xz = (ex == 0);  xi = (ex == 255) && (fx == 0);  xn = (ex == 255) && (fx != 0);
        yz = (ey == 0);  yi = (ey == 255) && (fy == 0);  yn = (ey == 255) && (fy != 0);
        inv = (xi && yz) || (xz && yi);
        if (xn || yn || inv)
            return {(inv || (xn && fx < 64) || (yn && fy < 64)), 3'b000, 16'h7FC0};
        if (xi || yi) return {4'b0000, s, 8'hFF, 7'h00};
        if (xz || yz) return {4'b0000, s, 15'h0000};
        // exact product of the two 8-bit significands, then keep 8 significant bits
        p = longint'(128 + fx) * longint'(128 + fy);
        msb = 0;
        while ((p >> (msb + 1)) != 0) msb++;
        sh   = msb - 7;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q++;
        e = ex + ey - 127 + (msb - 14);
        if (q == 256) begin
            q = 128;
            e++;
        end
        if (e >= 255) return {4'b0101, s, 8'hFF, 7'h00};
        if (e <= 0)   return {2'b00, 1'b1, (rem != 0), s, 15'h0000};
        return {3'b000, (rem != 0), s, 8'(e), 7'(q)};
    endfunction

    function automatic exp_t vec_ref(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                     input logic [TAG_W-1:0] tag);
        exp_t        ev;
        logic [19:0] lr;
        ev.tag = tag;
        ev.r   = '0;
        ev.fl  = '0;
        for (int l = 0; l < LANES; l++) begin
            lr = ref_mul(x[16*l +: 16], y[16*l +: 16]);
            ev.r[16*l +: 16] = lr[15:0];
            ev.fl[4*l +: 4]  = lr[19:16];
        end
        return ev;
    endfunction

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 9))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7F80;
            3: return 16'hFF80;
            4: return 16'h7FC0;
            5: return 16'h0001 + 16'($urandom_range(0, 126));
            6: return {1'($urandom), 8'($urandom_range(120, 134)), 7'($urandom)};
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int l = 0; l < LANES; l++) v[16*l +: 16] = rand_op();
        return v;
    endfunction

    // Scoreboard: output transfers are popped before the same cycle's input push
    always @(negedge clk) begin
        exp_t ev;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                seen_tags.push_back(out_tag);
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL stray_beat: tag %0h emerged with nothing outstanding", out_tag);
                end
                if (sb.size() > 0) begin
                    ev = sb.pop_front();
                    chk("sb_out_r", out_r, ev.r);
                    chk("sb_out_tag", out_tag, ev.tag);
`ifdef FPMUL_BF16_FLAGS_EN
                    chk("sb_out_flags", out_flags, ev.fl);
`endif
                end
            end
            if (in_valid && in_ready) sb.push_back(vec_ref(in_x, in_y, in_tag));
        end
    end

    task automatic directed(input string name, input logic [DW-1:0] x, input logic [DW-1:0] y,
                            input logic [TAG_W-1:0] tag, input logic [DW-1:0] expr);
        @(posedge clk); #1;
        in_x = x; in_y = y; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (PIPE - 1) begin
            chk({name, "_early"}, out_valid, 0);
            @(posedge clk); #1;
        end
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_r"}, out_r, expr);
        chk({name, "_tag"}, out_tag, tag);
        @(posedge clk); #1;
    endtask

    task automatic wait_accept(input string name);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        chk({name, "_accept"}, ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        bit done = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                done = 1;
                break;
            end
        end
        chk({name, "_drain"}, done, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic products, RNE ties, specials and range limits (lane 1 in the upper half)
        directed("basic",  32'h3F80_4000, 32'h4040_4040, 4'h5, 32'h4040_40C0);
        directed("rne",    32'h3F81_3F81, 32'h3FC0_3F81, 4'h6, 32'h3FC2_3F82);
        directed("nan",    32'h7F80_0000, 32'h0000_7F80, 4'h7, 32'h7FC0_7FC0);
        directed("inf",    32'hFF80_8000, 32'h4000_3F80, 4'h8, 32'hFF80_8000);
        directed("range",  32'h7F7F_0080, 32'h4000_3F00, 4'h9, 32'h7F80_0000);
        directed("daz",    32'h0001_4000, 32'h4000_7FC1, 4'hA, 32'h0000_7FC0);

        // Backpressure: tags 1,2,3 back to back while the output stalls
        seen_tags.delete();
        out_ready = 1'b0;
        in_x = rand_vec(); in_y = rand_vec(); in_tag = 4'h1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_x = rand_vec(); in_y = rand_vec(); in_tag = 4'h2;
        @(posedge clk); #1;
        in_x = rand_vec(); in_y = rand_vec(); in_tag = 4'h3;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_tag", out_tag, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept("bp_tag3");
        in_valid = 1'b0;
        drain("bp");
        chk("bp_count", seen_tags.size(), 3);
        for (int i = 0; i < seen_tags.size() && i < 3; i++)
            chk("bp_order", seen_tags[i], i + 1);

        // Reset with two beats in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_x = rand_vec(); in_y = rand_vec(); in_tag = 4'hB; in_valid = 1'b1;
        @(posedge clk); #1;
        in_tag = 4'hC;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_tag", out_tag, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("no_stale", out_valid, 0);
        end
        directed("post_rst", 32'h4000_C000, 32'h4040_3F80, 4'hD, 32'h40C0_C000);

        // Randomized traffic with random bubbles and backpressure
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc || !in_valid) begin
                if ($urandom_range(0, 3) != 0) begin
                    in_x = rand_vec(); in_y = rand_vec(); in_tag = 4'($urandom);
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        if (!acc && in_valid) wait_accept("rand_last");
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpmul_bf16_simd.md
FPMUL_BF16_SIMD -- requirements
Module: fpmul_bf16_simd

Interface
REQ-001 SHALL have parameter LANES, default 2: number of bf16 lanes, minimum 1.
REQ-002 SHALL have parameter PIPE_STAGES, default 2: cycles from input accept to out_valid, minimum 1.
REQ-003 SHALL have parameter TAG_W, default 4: width of the sideband tag carried alongside each beat.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  input beat valid.
REQ-007 in_ready  out  1  block accepts a beat this cycle.
REQ-008 in_x  in  16*LANES  multiplicand; lane i occupies bits [16i+15:16i].
REQ-009 in_y  in  16*LANES  multiplier; same lane packing as in_x.
REQ-010 in_tag  in  TAG_W  sideband, returned unmodified with the beat's result.
REQ-011 out_valid  out  1  result beat valid.
REQ-012 out_ready  in  1  downstream accepts the result.
REQ-013 out_r  out  16*LANES  bf16 products, same lane packing as in_x.
REQ-014 out_tag  out  TAG_W  tag of the beat on out_r.

Function
REQ-015 Transfers SHALL occur on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-016 Pipeline advance SHALL be global: adv = !out_valid || out_ready; in_ready = adv.
REQ-017 With adv held high, a beat accepted at edge N SHALL appear on out_* after edge N+PIPE_STAGES-1, i.e. latency PIPE_STAGES cycles; full throughput is 1 beat per cycle.
REQ-018 While adv=0, all stage registers and out_* SHALL hold; no beat is lost, duplicated or reordered.
REQ-019 A bubble (adv=1, in_valid=0) SHALL propagate as an invalid stage.
REQ-020 Per lane: sign = sx^sy; significand product 8x8 with hidden bit; normalise by at most 1; exponent = ex+ey-127(+1 if normalised); round to 7 fraction bits with RNE.
REQ-021 Subnormal inputs SHALL be treated as signed zero (DAZ).
REQ-022 Rounding SHALL precede range checks: rounded exponent >=255 -> signed Inf; <=0 -> signed zero (FTZ).
REQ-023 Any NaN operand, or Inf times zero, SHALL yield canonical quiet NaN 16'h7FC0.
REQ-024 Inf times nonzero finite SHALL yield signed Inf; zero times finite SHALL yield signed zero.
REQ-025 Lanes SHALL be fully independent; a special value in one lane SHALL NOT affect another lane.

Reset
REQ-026 On rst_n=0 all stage valids, out_valid, out_r and out_tag SHALL clear to 0; in_ready SHALL then read 1.
REQ-027 Reset mid-operation SHALL discard all in-flight beats; the first beat after deassertion SHALL see normal latency.

Configuration
REQ-028 Macro FPMUL_BF16_FLAGS_EN SHALL, when defined, add out_flags (out, 4*LANES, per-lane {NV,OF,UF,NX}, aligned with out_r), sticky_flags (out, 4*LANES) and flags_clr (in, 1).
REQ-029 When FPMUL_BF16_FLAGS_EN is defined, sticky update SHALL be sticky <= (flags_clr ? 0 : sticky) | (output transfer ? out_flags : 0); a same-cycle set SHALL survive a clear.
REQ-030 When FPMUL_BF16_FLAGS_EN is undefined, these ports and all flag logic SHALL be absent; datapath results SHALL be identical.

Structure
REQ-031 fpall_pkg SHALL hold bf16_t (packed sign/exp[7:0]/frac[6:0]), BF16_BIAS=127, BF16_QNAN=16'h7FC0 and the flag struct.
REQ-032 The lane datapath SHALL be a combinational sub-module fpmul_bf16_lane, instantiated LANES times; the top SHALL own the handshake and PIPE_STAGES register stages.

Verification
REQ-033 LANES=2: in_x=3F80_4000, in_y=4040_4040 -> out_r=4040_40C0 after 2 cycles, with tag echoed.
REQ-034 RNE tie: lane 3F81*3FC0 -> 3FC2; 3F81*3F81 -> 3F82.
REQ-035 Specials: in_x=7F80_0000, in_y=0000_7F80 -> 7FC0_7FC0 with NV; FF80*4000 -> FF80.
REQ-036 Range: 7F7F*4000 -> 7F80 with OF,NX; 0080*3F00 -> 0000 with UF.
REQ-037 Backpressure: issue tags 1,2,3 back-to-back, hold out_ready=0 five cycles -> in_ready=0 while out_valid is held; after release, tags 1,2,3 emerge in order, once each.
REQ-038 Assert rst_n=0 with 2 beats in flight -> out_valid=0 and no stale beat emerges after release.
